game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/ttt_pkg.sv | 31 +++
 rtl/win_check.sv | 36 +++
 rtl/game_ctrl.sv | 165 ++++++++++++++++
 tb/tb_game_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe game controller.
package ttt_pkg;

  localparam int NUM_CELLS = 9;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    X     = 2'b01,
    O     = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    PLAY  = 2'b00,
    CHECK = 2'b01,
    SYNC  = 2'b10,
    OVER  = 2'b11
  } ctrl_state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_X    = 2'b01;
  localparam logic [1:0] WIN_O    = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  // Cell indices of each line: rows, columns, main diagonal, anti-diagonal.
  localparam int WIN_LINES [8][3] = '{
    '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
    '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
    '{0, 4, 8}, '{2, 4, 6}
  };

endpackage

// File: rtl/win_check.sv
// Combinational line evaluation over the working board.
// Reports whether any line is complete, a one-hot winning line (lowest
// index wins if a move completes two lines at once) and occupied count.
module win_check
  import ttt_pkg::*;
(
  input  logic [17:0] wboard,
  output logic        line_done,
  output logic [7:0]  win_line,
  output logic [3:0]  occupied
);

  logic [7:0] hit;

  for (genvar l = 0; l < 8; l++) begin : g_line
    logic [1:0] c0, c1, c2;
    assign c0 = wboard[2*WIN_LINES[l][0] +: 2];
    assign c1 = wboard[2*WIN_LINES[l][1] +: 2];
    assign c2 = wboard[2*WIN_LINES[l][2] +: 2];
    assign hit[l] = (c0 != EMPTY) && (c0 == c1) && (c1 == c2);
  end

  // Isolate the lowest complete line so win_line stays one-hot.
  always_comb begin
    line_done = |hit;
    win_line  = hit & (~hit + 8'd1);
  end

  // Count non-empty cells for draw detection.
  always_comb begin
    occupied = '0;
    for (int i = 0; i < NUM_CELLS; i++)
      if (wboard[2*i +: 2] != EMPTY) occupied = occupied + 4'd1;
  end

endmodule

// File: rtl/game_ctrl.sv
// Tic-tac-toe game controller with tear-free display board.
// Moves land in a working board; the displayed board is only reloaded on
// frame_start. Optional turn timeout enabled by GAME_CTRL_TIMEOUT_EN.
module game_ctrl
  import ttt_pkg::*;
#(
  parameter int TIMEOUT_FRAMES = 600
) (
  input  logic        CLK25,
  input  logic        RST_BTN,
  input  logic        frame_start,
  input  logic        new_game,
  input  logic        move_valid,
  input  logic [3:0]  move_cell,
  output logic        move_ready,
  output logic        move_ack,
  output logic        move_err,
  output logic [17:0] board,
  output logic        turn,
  output logic [1:0]  winner,
  output logic [7:0]  win_line,
  output logic        game_over,
  output logic        timeout
);

  ctrl_state_t state, state_d;
  logic [17:0] wboard;
  logic [31:0] wb_ext;
  logic [1:0]  cell_val;
  logic        take, cell_ok, legal, illegal, expire;
  logic        line_done, done_q, full_q;
  logic [7:0]  chk_line, line_q;
  logic [3:0]  occupied;
  cell_t       mark;

  win_check u_win_check (
    .wboard    (wboard),
    .line_done (line_done),
    .win_line  (chk_line),
    .occupied  (occupied)
  );

  assign move_ready = (state == PLAY);
  assign take       = move_valid && move_ready;
  assign wb_ext     = {14'b0, wboard};
  assign cell_val   = wb_ext[{move_cell, 1'b0} +: 2];
  assign cell_ok    = (move_cell <= 4'd8) && (cell_val == EMPTY);
  assign legal      = take && !new_game && cell_ok;
  assign illegal    = take && !new_game && !cell_ok;
  assign mark       = turn ? O : X;

  // State register.
  always_ff @(posedge CLK25 or negedge RST_BTN) begin
    if (!RST_BTN) state <= PLAY;
    else          state <= state_d;
  end

  // Next-state logic; new_game overrides everything.
  always_comb begin
    state_d = state;
    case (state)
      PLAY:    if (legal) state_d = CHECK;
      CHECK:   state_d = SYNC;
      SYNC:    if (frame_start) state_d = (done_q || full_q) ? OVER : PLAY;
      OVER:    state_d = OVER;
      default: state_d = PLAY;
    endcase
    if (new_game) state_d = PLAY;
  end

  // Working board, result latching, display and status outputs.
  always_ff @(posedge CLK25 or negedge RST_BTN) begin
    if (!RST_BTN) begin
      wboard    <= '0;
      board     <= '0;
      turn      <= 1'b0;
      winner    <= WIN_NONE;
      win_line  <= '0;
      game_over <= 1'b0;
      move_ack  <= 1'b0;
      move_err  <= 1'b0;
      done_q    <= 1'b0;
      full_q    <= 1'b0;
      line_q    <= '0;
    end else begin
      move_ack <= 1'b0;
      move_err <= 1'b0;
      if (new_game) begin
        wboard    <= '0;
        board     <= '0;
        turn      <= 1'b0;
        winner    <= WIN_NONE;
        win_line  <= '0;
        game_over <= 1'b0;
      end else begin
        case (state)
          PLAY: begin
            if (legal) begin
              for (int i = 0; i < NUM_CELLS; i++)
                if (move_cell == 4'(i)) wboard[2*i +: 2] <= mark;
              move_ack <= 1'b1;
            end else if (illegal) begin
              move_err <= 1'b1;
            end else if (expire) begin
              turn <= ~turn;
            end
          end
          CHECK: begin
            done_q <= line_done;
            line_q <= chk_line;
            full_q <= (occupied == 4'd9);
          end
          SYNC: begin
            if (frame_start) begin
              board <= wboard;
              if (done_q) begin
                winner    <= turn ? WIN_O : WIN_X;
                win_line  <= line_q;
                game_over <= 1'b1;
              end else if (full_q) begin
                winner    <= WIN_DRAW;
                win_line  <= '0;
                game_over <= 1'b1;
              end else begin
                turn <= ~turn;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef GAME_CTRL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_FRAMES - 1);

  logic [CW-1:0] frame_cnt;

  // A taken move on the expiring frame wins over the timeout.
  assign expire = (state == PLAY) && frame_start && !take && !new_game &&
                  (frame_cnt == LAST);

  // Idle-frame counter and forfeit pulse.
  always_ff @(posedge CLK25 or negedge RST_BTN) begin
    if (!RST_BTN) begin
      frame_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      timeout <= expire;
      if (new_game || legal)
        frame_cnt <= '0;
      else if (state == PLAY && frame_start && !take)
        frame_cnt <= expire ? '0 : frame_cnt + 1'b1;
    end
  end
`else
  logic unused_tf;
  assign unused_tf = (TIMEOUT_FRAMES > 0);
  assign expire    = 1'b0;
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Directed self-checking bench for game_ctrl.
module tb_game_ctrl;

  logic        CLK25 = 1'b0;
  logic        RST_BTN = 1'b0;
  logic        frame_start = 1'b0;
  logic        new_game = 1'b0;
  logic        move_valid = 1'b0;
  logic [3:0]  move_cell = '0;
  logic        move_ready, move_ack, move_err, turn, game_over, timeout;
  logic [17:0] board;
  logic [1:0]  winner;
  logic [7:0]  win_line;

  int checks = 0;
  int failures = 0;

  game_ctrl #(.TIMEOUT_FRAMES(3)) dut (
    .CLK25       (CLK25),
    .RST_BTN     (RST_BTN),
    .frame_start (frame_start),
    .new_game    (new_game),
    .move_valid  (move_valid),
    .move_cell   (move_cell),
    .move_ready  (move_ready),
    .move_ack    (move_ack),
    .move_err    (move_err),
    .board       (board),
    .turn        (turn),
    .winner      (winner),
    .win_line    (win_line),
    .game_over   (game_over),
    .timeout     (timeout)
  );

  always #5 CLK25 = ~CLK25;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK25); #1;
  endtask

  task automatic move(input logic [3:0] c);
    move_valid = 1'b1; move_cell = c; tick(); move_valid = 1'b0;
  endtask

  task automatic frame();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
  endtask

  task automatic play(input logic [3:0] c);
    move(c);
    chk("play_ack", move_ack, 1);
    tick();
    frame();
  endtask

  task automatic restart();
    new_game = 1'b1; tick(); new_game = 1'b0;
  endtask

  initial begin
    // reset values
    #12;
    chk("rst_board", board, 0);
    chk("rst_turn", turn, 0);
    chk("rst_winner", winner, 0);
    chk("rst_line", win_line, 0);
    chk("rst_over", game_over, 0);
    chk("rst_ack", move_ack, 0);
    chk("rst_err", move_err, 0);
    chk("rst_tmo", timeout, 0);
    RST_BTN = 1'b1;
    tick();
    chk("rst_ready", move_ready, 1);

    // X wins top row
    play(0);
    chk("w_b0", board, 18'h00001);
    chk("w_turn1", turn, 1);
    play(3); play(1); play(4); play(2);
    chk("w_winner", winner, 2'b01);
    chk("w_line", win_line, 8'h01);
    chk("w_over", game_over, 1);
    chk("w_low", board[5:0], 6'b010101);
    chk("w_board", board, 18'h00295);
    move(5);
    chk("over_ack", move_ack, 0);
    chk("over_err", move_err, 0);
    chk("over_board", board, 18'h00295);

    // new_game clears, then illegal moves
    restart();
    chk("ng_board", board, 0);
    chk("ng_over", game_over, 0);
    chk("ng_winner", winner, 0);
    chk("ng_ready", move_ready, 1);
    play(4);
    chk("il_turn", turn, 1);
    move(4);
    chk("il_err", move_err, 1);
    chk("il_ack", move_ack, 0);
    chk("il_turn2", turn, 1);
    chk("il_ready", move_ready, 1);
    tick();
    chk("il_errpulse", move_err, 0);
    move(12);
    chk("il12_err", move_err, 1);
    chk("il_board", board, 18'h00100);

    // draw
    restart();
    play(0); play(1); play(2); play(4); play(3); play(5); play(7); play(6);
    chk("d_nowin", winner, 0);
    play(8);
    chk("d_winner", winner, 2'b11);
    chk("d_line", win_line, 0);
    chk("d_over", game_over, 1);
    chk("d_board", board, 18'h16A59);
    chk("d_ready", move_ready, 0);
    move(0);
    chk("d_ack", move_ack, 0);
    chk("d_err", move_err, 0);

    // display holds until frame_start
    restart();
    move(0);
    chk("s_ack", move_ack, 1);
    for (int i = 0; i < 100; i++) tick();
    chk("s_hold", board, 0);
    chk("s_notready", move_ready, 0);
    frame();
    chk("s_board", board, 18'h00001);
    chk("s_ready", move_ready, 1);

    // new_game with coincident move
    new_game = 1'b1; move_valid = 1'b1; move_cell = 4'd2;
    tick();
    new_game = 1'b0; move_valid = 1'b0;
    chk("ngm_ack", move_ack, 0);
    chk("ngm_err", move_err, 0);
    chk("ngm_board", board, 0);
    chk("ngm_turn", turn, 0);
    tick();
    chk("ngm_ack2", move_ack, 0);

    // async reset mid-SYNC
    play(0);
    move(4);
    tick();
    chk("ar_pre", board, 18'h00001);
    #2 RST_BTN = 1'b0; #1;
    chk("ar_board", board, 0);
    chk("ar_turn", turn, 0);
    chk("ar_ack", move_ack, 0);
    chk("ar_over", game_over, 0);
    #3 RST_BTN = 1'b1;
    tick();
    chk("ar_ready", move_ready, 1);

    // turn timeout
    restart();
    frame(); tick(); frame(); tick(); frame();
`ifdef GAME_CTRL_TIMEOUT_EN
    chk("to_pulse", timeout, 1);
    chk("to_turn", turn, 1);
    tick();
    chk("to_clear", timeout, 0);
    frame(); tick(); frame(); tick();
    frame_start = 1'b1;
    move(0);
    frame_start = 1'b0;
    chk("tm_ack", move_ack, 1);
    chk("tm_tmo", timeout, 0);
`else
    chk("to_off", timeout, 0);
    chk("to_turn", turn, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
